// File: rtl/mem_write_checker.sv
//------------------------------------------------------------------------------
// Module  : mem_write_checker
// Brief   : Compares core data-memory stores against a loaded expected-store
//           table and reports sticky pass/fail with a cause code.
//           Define MWC_ANYORDER_EN to accept table entries in any order.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_checker #(
   parameter int               DATA_W      = 32,
   parameter int               ADDR_W      = 32,
   parameter int               NUM_EXP     = 4,
   parameter int               TIMEOUT_CYC = 4096,
   parameter logic [ADDR_W-1:0] IGN_BASE   = 80,
   parameter logic [ADDR_W-1:0] IGN_MASK   = 'h3,
   localparam int              IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
   localparam int              CNT_W       = $clog2(NUM_EXP + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] dataadr,
   input  logic [DATA_W-1:0] writedata,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   localparam int             c_TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int             c_TMO_LAST   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [c_TW-1:0] c_TMO_LAST_V = c_TW'(c_TMO_LAST);
   localparam logic [CNT_W-1:0] c_NUM_EXP_V = CNT_W'(NUM_EXP);
   localparam logic [1:0]     c_CODE_MIS   = 2'd1;
   localparam logic [1:0]     c_CODE_TMO   = 2'd2;
   localparam logic [1:0]     c_CODE_DUP   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_exp_addr [NUM_EXP];
   logic [DATA_W-1:0] r_exp_data [NUM_EXP];

   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_match_cnt;
   logic [c_TW-1:0]   r_tcnt;
   logic [1:0]        r_fail_code;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [DATA_W-1:0] r_fail_data;

   logic              w_hit_new;
   logic              w_hit_dup;
   logic              w_ign;
   logic              w_last;
   logic              w_tmo_exp;
   logic              w_do_match;
   logic              w_fail_mis;
   logic              w_fail_dup;
   logic              w_fail_tmo;
   logic [CNT_W-1:0]  w_len_eff;

   assign w_ign     = (dataadr & ~IGN_MASK) == (IGN_BASE & ~IGN_MASK);
   assign w_last    = (r_match_cnt + CNT_W'(1)) == r_len;
   assign w_tmo_exp = (TIMEOUT_CYC != 0) && (r_tcnt == c_TMO_LAST_V);
   assign w_len_eff = ((cfg_len == '0) || (cfg_len > c_NUM_EXP_V)) ? c_NUM_EXP_V : cfg_len;

`ifdef MWC_ANYORDER_EN
   logic [NUM_EXP-1:0] r_done;
   logic [NUM_EXP-1:0] w_hit;
   logic [NUM_EXP-1:0] w_new;
   logic [NUM_EXP-1:0] w_new_low;

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_EXP; i++) begin
         w_hit[i] = (CNT_W'(i) < r_len) &&
                    (r_exp_addr[i] == dataadr) && (r_exp_data[i] == writedata);
      end
   end

   assign w_new     = w_hit & ~r_done;
   // isolate the lowest set bit so simultaneous hits retire one entry
   assign w_new_low = w_new & (~w_new + NUM_EXP'(1));
   assign w_hit_new = |w_new;
   assign w_hit_dup = (|w_hit) && !w_hit_new;
`else
   logic [IDX_W-1:0] w_cur;

   assign w_cur     = r_match_cnt[IDX_W-1:0];
   assign w_hit_new = (r_exp_addr[w_cur] == dataadr) && (r_exp_data[w_cur] == writedata);
   assign w_hit_dup = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_do_match  = 1'b0;
      w_fail_mis  = 1'b0;
      w_fail_dup  = 1'b0;
      w_fail_tmo  = 1'b0;
      case (r_state)
         S_IDLE, S_PASS, S_FAIL: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (memwrite && w_hit_new) begin
               w_do_match = 1'b1;
               if (w_last) w_state_nxt = S_PASS;
            end else if (memwrite && w_hit_dup) begin
               w_fail_dup = 1'b1;
            end else if (memwrite && !w_ign) begin
               w_fail_mis = 1'b1;
            end
            // a completing match in the expiring cycle beats the timeout
            if (w_tmo_exp && (w_state_nxt != S_PASS) && !w_fail_mis && !w_fail_dup)
               w_fail_tmo = 1'b1;
            if (w_fail_mis || w_fail_dup || w_fail_tmo) w_state_nxt = S_FAIL;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cfg_we && (r_state != S_RUN) && ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_EXP))) begin
         r_exp_addr[cfg_idx] <= cfg_addr;
         r_exp_data[cfg_idx] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_len       <= '0;
         r_match_cnt <= '0;
         r_tcnt      <= '0;
         r_fail_code <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
`ifdef MWC_ANYORDER_EN
         r_done      <= '0;
`endif
      end else if ((r_state != S_RUN) && start) begin
         r_len       <= w_len_eff;
         r_match_cnt <= '0;
         r_tcnt      <= '0;
         r_fail_code <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
`ifdef MWC_ANYORDER_EN
         r_done      <= '0;
`endif
      end else if (r_state == S_RUN) begin
         r_tcnt <= r_tcnt + c_TW'(1);
         if (w_do_match) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
`ifdef MWC_ANYORDER_EN
            r_done      <= r_done | w_new_low;
`endif
         end
         if (w_fail_mis || w_fail_dup) begin
            r_fail_code <= w_fail_dup ? c_CODE_DUP : c_CODE_MIS;
            r_fail_addr <= dataadr;
            r_fail_data <= writedata;
         end else if (w_fail_tmo) begin
            r_fail_code <= c_CODE_TMO;
         end
      end
   end

   assign busy      = (r_state == S_RUN);
   assign pass      = (r_state == S_PASS);
   assign fail      = (r_state == S_FAIL);
   assign fail_code = r_fail_code;
   assign match_cnt = r_match_cnt;
   assign fail_addr = r_fail_addr;
   assign fail_data = r_fail_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_write_checker
// Brief   : Directed self-checking bench for mem_write_checker (TIMEOUT_CYC=16).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_addr;
   logic [31:0] cfg_data;
   logic [2:0]  cfg_len;
   logic        start;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        busy;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;
   logic [2:0]  match_cnt;
   logic [31:0] fail_addr;
   logic [31:0] fail_data;

   int errors = 0;
   int checks = 0;

   mem_write_checker #(
      .DATA_W      (32),
      .ADDR_W      (32),
      .NUM_EXP     (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_len   (cfg_len),
      .start     (start),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .busy      (busy),
      .pass      (pass),
      .fail      (fail),
      .fail_code (fail_code),
      .match_cnt (match_cnt),
      .fail_addr (fail_addr),
      .fail_data (fail_data)
   );

   always #5 clk = ~clk;

   // {busy, pass, fail, fail_code}
   function automatic logic [4:0] flags();
      return {busy, pass, fail, fail_code};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      start    = 1'b0;
      memwrite = 1'b0;
      rst      = 1'b1;
   endtask

   task automatic cfg(input int idx, input int a, input int d);
      cfg_we   = 1'b1;
      cfg_idx  = idx[1:0];
      cfg_addr = a;
      cfg_data = d;
      step();
   endtask

   task automatic run(input int len);
      start   = 1'b1;
      cfg_len = len[2:0];
      step();
   endtask

   task automatic st(input int a, input int d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      checks++;
      if (flags() !== 5'b00000 || match_cnt !== 3'd0 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_state flags=%b cnt=%0d addr=%0d data=%0d required 00000/0/0/0",
                  flags(), match_cnt, fail_addr, fail_data);
      end
   endtask

   task automatic test_inorder_pass();
      cfg(0, 84, 7);
      run(1);
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd0) begin
         errors++;
         $display("FAIL t1_started flags=%b cnt=%0d required 10000/0", flags(), match_cnt);
      end
      st(80, 11);
      st(80, 22);
      checks++;
      if (flags() !== 5'b10000) begin
         errors++;
         $display("FAIL t1_ignored flags=%b required 10000", flags());
      end
      st(84, 7);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd1) begin
         errors++;
         $display("FAIL t1_pass flags=%b cnt=%0d required 01000/1", flags(), match_cnt);
      end
   endtask

   task automatic test_mismatch();
      run(1);
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd0) begin
         errors++;
         $display("FAIL t2_restart flags=%b cnt=%0d required 10000/0", flags(), match_cnt);
      end
      st(88, 7);
      checks++;
      if (flags() !== 5'b00101 || fail_addr !== 32'd88 || fail_data !== 32'd7) begin
         errors++;
         $display("FAIL t2_mismatch flags=%b addr=%0d data=%0d required 00101/88/7",
                  flags(), fail_addr, fail_data);
      end
   endtask

   task automatic test_timeout();
      run(1);
      checks++;
      if (flags() !== 5'b10000 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
         errors++;
         $display("FAIL t3_cleared flags=%b addr=%0d data=%0d required 10000/0/0",
                  flags(), fail_addr, fail_data);
      end
      repeat (15) step();
      checks++;
      if (flags() !== 5'b10000) begin
         errors++;
         $display("FAIL t3_before_expiry flags=%b required 10000", flags());
      end
      step();
      checks++;
      if (flags() !== 5'b00110 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
         errors++;
         $display("FAIL t3_timeout flags=%b addr=%0d data=%0d required 00110/0/0",
                  flags(), fail_addr, fail_data);
      end
   endtask

   task automatic test_timeout_last_match();
      run(1);
      repeat (15) step();
      st(84, 7);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd1) begin
         errors++;
         $display("FAIL tmo_match_wins flags=%b cnt=%0d required 01000/1", flags(), match_cnt);
      end
   endtask

   task automatic test_cfg_locked();
      run(1);
      cfg(0, 100, 1);
      st(84, 7);
      checks++;
      if (flags() !== 5'b01000) begin
         errors++;
         $display("FAIL cfg_locked flags=%b required 01000", flags());
      end
   endtask

   task automatic test_order();
      cfg(1, 92, 3);
      run(2);
      st(92, 3);
`ifdef MWC_ANYORDER_EN
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd1) begin
         errors++;
         $display("FAIL t4_first flags=%b cnt=%0d required 10000/1", flags(), match_cnt);
      end
      st(84, 7);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd2) begin
         errors++;
         $display("FAIL t4_pass flags=%b cnt=%0d required 01000/2", flags(), match_cnt);
      end
`else
      checks++;
      if (flags() !== 5'b00101 || fail_addr !== 32'd92 || fail_data !== 32'd3 || match_cnt !== 3'd0) begin
         errors++;
         $display("FAIL t4_order flags=%b addr=%0d data=%0d cnt=%0d required 00101/92/3/0",
                  flags(), fail_addr, fail_data, match_cnt);
      end
`endif
   endtask

   task automatic test_duplicate();
      run(2);
      st(84, 7);
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd1) begin
         errors++;
         $display("FAIL t5_first flags=%b cnt=%0d required 10000/1", flags(), match_cnt);
      end
      st(84, 7);
      checks++;
`ifdef MWC_ANYORDER_EN
      if (flags() !== 5'b00111 || fail_addr !== 32'd84) begin
         errors++;
         $display("FAIL t5_dup flags=%b addr=%0d required 00111/84", flags(), fail_addr);
      end
`else
      if (flags() !== 5'b00101 || fail_addr !== 32'd84) begin
         errors++;
         $display("FAIL t5_dup flags=%b addr=%0d required 00101/84", flags(), fail_addr);
      end
`endif
      run(2);
      st(84, 7);
      st(92, 3);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd2) begin
         errors++;
         $display("FAIL t5_rerun flags=%b cnt=%0d required 01000/2", flags(), match_cnt);
      end
   endtask

   task automatic test_len_clamp();
      cfg(2, 96, 5);
      cfg(3, 100, 6);
      run(0);
      st(84, 7);
      st(92, 3);
      st(96, 5);
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd3) begin
         errors++;
         $display("FAIL len0_partial flags=%b cnt=%0d required 10000/3", flags(), match_cnt);
      end
      st(100, 6);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd4) begin
         errors++;
         $display("FAIL len0_pass flags=%b cnt=%0d required 01000/4", flags(), match_cnt);
      end
   endtask

   task automatic test_reset_midrun();
      run(2);
      st(84, 7);
      checks++;
      if (flags() !== 5'b10000 || match_cnt !== 3'd1) begin
         errors++;
         $display("FAIL t6_match flags=%b cnt=%0d required 10000/1", flags(), match_cnt);
      end
      rst = 1'b0;
      step();
      checks++;
      if (flags() !== 5'b00000 || match_cnt !== 3'd0 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
         errors++;
         $display("FAIL t6_reset flags=%b cnt=%0d addr=%0d data=%0d required 00000/0/0/0",
                  flags(), match_cnt, fail_addr, fail_data);
      end
      run(2);
      st(84, 7);
      st(92, 3);
      checks++;
      if (flags() !== 5'b01000 || match_cnt !== 3'd2) begin
         errors++;
         $display("FAIL t6_fresh flags=%b cnt=%0d required 01000/2", flags(), match_cnt);
      end
   endtask

   initial begin
      rst       = 1'b0;
      cfg_we    = 1'b0;
      cfg_idx   = '0;
      cfg_addr  = '0;
      cfg_data  = '0;
      cfg_len   = '0;
      start     = 1'b0;
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;

      test_reset();
      test_inorder_pass();
      test_mismatch();
      test_timeout();
      test_timeout_last_match();
      test_cfg_locked();
      test_order();
      test_duplicate();
      test_len_clamp();
      test_reset_midrun();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire
